controle_muldiv: RTL and testbench

Multi-cycle sequencer for the ALU's multiply, divide and remainder operations, which are too slow to complete in one cycle.
- Accepts an operation with a start/busy/done handshake and iterates over 32 cycles (shift-add multiply, restoring divide).
- Holds the results in HI/LO registers.
- Sits beside the ALU; the pipeline control stalls on ocupado and collects the result on pronto.

---
 rtl/controle_muldiv_pkg.sv | 16 +
 rtl/controle_muldiv_passo_divisao.sv | 25 ++
 rtl/controle_muldiv.sv | 149 ++++++++++++++
 tb/tb_controle_muldiv.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/controle_muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU opcodes and FSM states.
package controle_muldiv_pkg;

  // Opcodes use the same encoding as the ALU so ulaOP can be forwarded unchanged.
  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_DIV   = 5'b00011;
  localparam logic [4:0] OP_RESTO = 5'b00100;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FIM    = 2'd3
  } estado_t;

endpackage

// File: rtl/controle_muldiv_passo_divisao.sv
// One combinational restoring-divide step: shift {remainder, quotient} left,
// trial-subtract the divisor and keep the difference when it does not borrow.
module passo_divisao #(
  parameter int LARGURA = 32
) (
  input  logic [LARGURA-1:0] resto_i,
  input  logic [LARGURA-1:0] quoc_i,
  input  logic [LARGURA-1:0] divisor_i,
  output logic [LARGURA-1:0] resto_o,
  output logic [LARGURA-1:0] quoc_o
);

  logic [LARGURA:0] desloc;
  logic [LARGURA:0] dif;

  // Remainder is always below the divisor, so the shifted value fits in LARGURA+1
  // bits and the top bit of the difference is exactly the borrow.
  always_comb begin
    desloc  = {resto_i, quoc_i[LARGURA-1]};
    dif     = desloc - {1'b0, divisor_i};
    resto_o = dif[LARGURA] ? desloc[LARGURA-1:0] : dif[LARGURA-1:0];
    quoc_o  = {quoc_i[LARGURA-2:0], ~dif[LARGURA]};
  end

endmodule

// File: rtl/controle_muldiv.sv
// Multi-cycle multiply / divide / remainder sequencer with start/busy/done handshake.
// A single 2*LARGURA accumulator holds {hi, lo} for multiply and {remainder, quotient}
// for divide; one operand register holds the multiplicand or the divisor.
module controle_muldiv
  import controle_muldiv_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [4:0]         ulaOP,
  input  logic [LARGURA-1:0] RS,
  input  logic [LARGURA-1:0] RT,
  output logic               ocupado,
  output logic               pronto,
  output logic [LARGURA-1:0] saidaHI,
  output logic [LARGURA-1:0] saidaLO,
  output logic [LARGURA-1:0] saidaRes
);

  localparam int CW = $clog2(LARGURA) + 1;

  estado_t                 estado_q, estado_d;
  logic [CW-1:0]           cont_q, cont_d;
  logic [4:0]              op_q, op_d;
  logic [LARGURA-1:0]      opnd_q, opnd_d;
  logic [2*LARGURA-1:0]    acc_q, acc_d;
  logic                    ocupado_q, ocupado_d;
  logic                    pronto_q, pronto_d;
  logic [LARGURA-1:0]      hi_q, hi_d;
  logic [LARGURA-1:0]      lo_q, lo_d;
  logic [LARGURA-1:0]      res_q, res_d;

  logic [LARGURA:0]        soma;
  logic [2*LARGURA-1:0]    mult_prox;
  logic [LARGURA-1:0]      div_resto;
  logic [LARGURA-1:0]      div_quoc;

  passo_divisao #(.LARGURA(LARGURA)) u_passo (
    .resto_i   (acc_q[2*LARGURA-1:LARGURA]),
    .quoc_i    (acc_q[LARGURA-1:0]),
    .divisor_i (opnd_q),
    .resto_o   (div_resto),
    .quoc_o    (div_quoc)
  );

  // Shift-add multiply step: conditional add into the upper half (carry in the extra
  // bit of soma), then shift the whole accumulator right; the multiplier drains from lo.
  always_comb begin
    soma      = {1'b0, acc_q[2*LARGURA-1:LARGURA]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mult_prox = {soma, acc_q[LARGURA-1:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_d     = res_q;
    case (estado_q)
      OCIOSO: begin
        // A start coinciding with the done pulse is dropped, not deferred.
        if (inicio && !pronto_q) begin
          if (ulaOP == OP_MULT) begin
            estado_d  = MULT;
            op_d      = ulaOP;
            opnd_d    = RS;
            acc_d     = {{LARGURA{1'b0}}, RT};
            cont_d    = CW'(LARGURA);
            ocupado_d = 1'b1;
          end else if (ulaOP == OP_DIV || ulaOP == OP_RESTO) begin
            estado_d  = DIV;
            op_d      = ulaOP;
            opnd_d    = RT;
            acc_d     = {{LARGURA{1'b0}}, RS};
            cont_d    = CW'(LARGURA);
            ocupado_d = 1'b1;
          end
        end
      end
      MULT: begin
        acc_d  = mult_prox;
        cont_d = cont_q - CW'(1);
        if (cont_q == CW'(1)) estado_d = FIM;
      end
      DIV: begin
        if (opnd_q == '0) begin
          // Divide by zero: quotient all ones, remainder is the dividend, no iteration.
          acc_d    = {acc_q[LARGURA-1:0], {LARGURA{1'b1}}};
          estado_d = FIM;
        end else begin
          acc_d  = {div_resto, div_quoc};
          cont_d = cont_q - CW'(1);
          if (cont_q == CW'(1)) estado_d = FIM;
        end
      end
      FIM: begin
        hi_d      = acc_q[2*LARGURA-1:LARGURA];
        lo_d      = acc_q[LARGURA-1:0];
        res_d     = (op_q == OP_RESTO) ? acc_q[2*LARGURA-1:LARGURA] : acc_q[LARGURA-1:0];
        pronto_d  = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and result registers; active-low reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      cont_q    <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_q     <= res_d;
    end
  end

  assign ocupado  = ocupado_q;
  assign pronto   = pronto_q;
  assign saidaHI  = hi_q;
  assign saidaLO  = lo_q;
  assign saidaRes = res_q;

endmodule

// File: tb/tb_controle_muldiv.sv
// Self-checking bench for controle_muldiv: directed cases plus random operations
// compared against plain-arithmetic expectations.
module tb_controle_muldiv;

  localparam logic [4:0] T_MULT  = 5'b00010;
  localparam logic [4:0] T_DIV   = 5'b00011;
  localparam logic [4:0] T_RESTO = 5'b00100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inicio = 1'b0;
  logic [4:0]  ulaOP = '0;
  logic [31:0] RS = '0;
  logic [31:0] RT = '0;
  logic        ocupado;
  logic        pronto;
  logic [31:0] saidaHI;
  logic [31:0] saidaLO;
  logic [31:0] saidaRes;

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;

  controle_muldiv #(.LARGURA(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .inicio   (inicio),
    .ulaOP    (ulaOP),
    .RS       (RS),
    .RT       (RT),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .saidaHI  (saidaHI),
    .saidaLO  (saidaLO),
    .saidaRes (saidaRes)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (pronto) pronto_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected results straight from the arithmetic definition of each operation.
  task automatic modelo(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic [31:0] res, output int lat);
    logic [63:0] p;
    if (op == T_MULT) begin
      p   = 64'(a) * 64'(b);
      hi  = p[63:32];
      lo  = p[31:0];
      lat = 33;
    end else if (b == 0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 2;
    end else begin
      hi  = a % b;
      lo  = a / b;
      lat = 33;
    end
    res = (op == T_RESTO) ? hi : lo;
  endtask

  // Issue one operation, optionally injecting a DIV 9/3 start k cycles in, and check it.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inject_at);
    logic [31:0] ehi, elo, eres;
    int elat, k;
    bit got, busy_ok;
    modelo(op, a, b, ehi, elo, eres, elat);
    @(negedge clock);
    inicio = 1'b1; ulaOP = op; RS = a; RT = b;
    @(negedge clock);
    inicio = 1'b0;
    check({tag, "_busy0"}, 64'(ocupado), 64'(1));
    k = 0; got = 0; busy_ok = 1;
    while (k < 100 && !got) begin
      @(negedge clock);
      k++;
      if (inject_at != 0 && k == inject_at) begin
        inicio = 1'b1; ulaOP = T_DIV; RS = 32'd9; RT = 32'd3;
      end else if (inject_at != 0 && k == inject_at + 1) begin
        inicio = 1'b0;
      end
      if (pronto) got = 1;
      else if (!ocupado) busy_ok = 0;
    end
    inicio = 1'b0;
    check({tag, "_lat"}, 64'(got ? k : -1), 64'(elat));
    check({tag, "_busy"}, 64'(busy_ok), 64'(1));
    check({tag, "_hi"}, 64'(saidaHI), 64'(ehi));
    check({tag, "_lo"}, 64'(saidaLO), 64'(elo));
    check({tag, "_res"}, 64'(saidaRes), 64'(eres));
    check({tag, "_busyend"}, 64'(ocupado), 64'(0));
    @(negedge clock);
    check({tag, "_pulse"}, 64'(pronto), 64'(0));
    $display("op=%0h a=%0h b=%0h hi=%0h lo=%0h res=%0h lat=%0d", op, a, b, saidaHI, saidaLO, saidaRes, k);
  endtask

  initial begin
    logic [4:0] rop;
    logic [31:0] ra, rb;
    int cnt0;

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ocupado", 64'(ocupado), 64'(0));
    check("rst_pronto", 64'(pronto), 64'(0));
    check("rst_hi", 64'(saidaHI), 64'(0));
    check("rst_lo", 64'(saidaLO), 64'(0));
    check("rst_res", 64'(saidaRes), 64'(0));
    reset = 1'b1;

    // Directed cases
    run_op("mul7x6", T_MULT, 32'd7, 32'd6, 0);
    run_op("mulmax", T_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div100_7", T_DIV, 32'd100, 32'd7, 0);
    run_op("rem100_7", T_RESTO, 32'd100, 32'd7, 0);
    run_op("div55_0", T_DIV, 32'd55, 32'd0, 0);
    run_op("rem55_0", T_RESTO, 32'd55, 32'd0, 0);
    run_op("div_big", T_DIV, 32'hFFFF_FFFF, 32'd1, 0);

    // Random operations
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 2))
        0: rop = T_MULT;
        1: rop = T_DIV;
        default: rop = T_RESTO;
      endcase
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = 32'($urandom_range(1, 1000));
      run_op("rand", rop, ra, rb, 0);
    end

    // Start while busy is ignored; exactly one done pulse
    cnt0 = pronto_cnt;
    run_op("mul3x5_inj", T_MULT, 32'd3, 32'd5, 10);
    repeat (40) @(negedge clock);
    #1;
    check("inj_one_pulse", 64'(pronto_cnt - cnt0), 64'(1));
    check("inj_idle", 64'(ocupado), 64'(0));

    // Reset mid-operation aborts without a done pulse
    cnt0 = pronto_cnt;
    @(negedge clock);
    inicio = 1'b1; ulaOP = T_DIV; RS = 32'd100; RT = 32'd7;
    @(negedge clock);
    inicio = 1'b0;
    repeat (14) @(negedge clock);
    check("abort_busy_before", 64'(ocupado), 64'(1));
    reset = 1'b0;
    @(negedge clock);
    check("abort_ocupado", 64'(ocupado), 64'(0));
    check("abort_pronto", 64'(pronto), 64'(0));
    check("abort_hi", 64'(saidaHI), 64'(0));
    check("abort_lo", 64'(saidaLO), 64'(0));
    check("abort_res", 64'(saidaRes), 64'(0));
    reset = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    check("abort_no_pulse", 64'(pronto_cnt - cnt0), 64'(0));

    // Unsupported opcode is ignored
    @(negedge clock);
    inicio = 1'b1; ulaOP = 5'b00000; RS = 32'd4; RT = 32'd2;
    @(negedge clock);
    inicio = 1'b0;
    check("badop_idle", 64'(ocupado), 64'(0));
    repeat (40) @(negedge clock);
    #1;
    check("badop_no_pulse", 64'(pronto_cnt - cnt0), 64'(0));
    check("badop_lo", 64'(saidaLO), 64'(0));
    $display("abort/badop sequence done ocupado=%0d pronto_count=%0d", ocupado, pronto_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
